// File: rtl/dma_fromhost_arb.sv
// Two-requester packet arbiter feeding one from-host DMA AXI-Stream channel.
// Grants are held for a whole packet and alternate between requesters on ties.
`timescale 1ns/1ps

module dma_fromhost_arb #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,

    input  logic [63:0]      s0_axis_fromhost_tdata,
    input  logic [7:0]       s0_axis_fromhost_tkeep,
    input  logic             s0_axis_fromhost_tvalid,
    input  logic             s0_axis_fromhost_tlast,
    output logic             s0_axis_fromhost_tready,

    input  logic [63:0]      s1_axis_fromhost_tdata,
    input  logic [7:0]       s1_axis_fromhost_tkeep,
    input  logic             s1_axis_fromhost_tvalid,
    input  logic             s1_axis_fromhost_tlast,
    output logic             s1_axis_fromhost_tready,

    output logic [63:0]      m_axis_fromhost_tdata,
    output logic [7:0]       m_axis_fromhost_tkeep,
    output logic             m_axis_fromhost_tvalid,
    output logic             m_axis_fromhost_tlast,
    input  logic             m_axis_fromhost_tready,
    output logic             m_axis_fromhost_tid,

    output logic             arb_busy,
    output logic [CNT_W-1:0] pkt_cnt0,
    output logic [CNT_W-1:0] pkt_cnt1
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_t;

    state_t state;
    logic   last_grant;
    logic   done0;
    logic   done1;

    // Final beat of the granted packet is being handed to the DMA channel.
    assign done0 = (state == GRANT0) && s0_axis_fromhost_tvalid
                   && s0_axis_fromhost_tlast && m_axis_fromhost_tready;
    assign done1 = (state == GRANT1) && s1_axis_fromhost_tvalid
                   && s1_axis_fromhost_tlast && m_axis_fromhost_tready;

    // Zero-latency stream mux; everything is forced quiet while rst is high.
    always_comb begin
        s0_axis_fromhost_tready = 1'b0;
        s1_axis_fromhost_tready = 1'b0;
        m_axis_fromhost_tdata   = 64'd0;
        m_axis_fromhost_tkeep   = 8'd0;
        m_axis_fromhost_tvalid  = 1'b0;
        m_axis_fromhost_tlast   = 1'b0;
        m_axis_fromhost_tid     = last_grant;
        arb_busy                = 1'b0;
        if (!rst) begin
            case (state)
                GRANT0: begin
                    m_axis_fromhost_tdata   = s0_axis_fromhost_tdata;
                    m_axis_fromhost_tkeep   = s0_axis_fromhost_tkeep;
                    m_axis_fromhost_tvalid  = s0_axis_fromhost_tvalid;
                    m_axis_fromhost_tlast   = s0_axis_fromhost_tlast;
                    s0_axis_fromhost_tready = m_axis_fromhost_tready;
                    m_axis_fromhost_tid     = 1'b0;
                    arb_busy                = 1'b1;
                end
                GRANT1: begin
                    m_axis_fromhost_tdata   = s1_axis_fromhost_tdata;
                    m_axis_fromhost_tkeep   = s1_axis_fromhost_tkeep;
                    m_axis_fromhost_tvalid  = s1_axis_fromhost_tvalid;
                    m_axis_fromhost_tlast   = s1_axis_fromhost_tlast;
                    s1_axis_fromhost_tready = m_axis_fromhost_tready;
                    m_axis_fromhost_tid     = 1'b1;
                    arb_busy                = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // A finishing port hands over directly to a waiting peer, never to itself.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            pkt_cnt0   <= '0;
            pkt_cnt1   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (s0_axis_fromhost_tvalid && (!s1_axis_fromhost_tvalid || last_grant))
                        state <= GRANT0;
                    else if (s1_axis_fromhost_tvalid)
                        state <= GRANT1;
                end
                GRANT0: begin
                    if (done0) begin
                        last_grant <= 1'b0;
                        pkt_cnt0   <= pkt_cnt0 + CNT_W'(1);
                        state      <= s1_axis_fromhost_tvalid ? GRANT1 : IDLE;
                    end
                end
                GRANT1: begin
                    if (done1) begin
                        last_grant <= 1'b1;
                        pkt_cnt1   <= pkt_cnt1 + CNT_W'(1);
                        state      <= s0_axis_fromhost_tvalid ? GRANT0 : IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dma_fromhost_arb.sv
// Scoreboard bench for dma_fromhost_arb: queue-fed requesters, expected beats
// (tid, payload, and cycle spacing) checked by an independent monitor.
`timescale 1ns/1ps

module tb_dma_fromhost_arb;

    localparam int unsigned CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [63:0]      s0_tdata, s1_tdata, m_tdata;
    logic [7:0]       s0_tkeep, s1_tkeep, m_tkeep;
    logic             s0_tvalid, s1_tvalid, m_tvalid;
    logic             s0_tlast, s1_tlast, m_tlast;
    logic             s0_tready, s1_tready, m_tready;
    logic             m_tid, arb_busy;
    logic [CNT_W-1:0] pkt_cnt0, pkt_cnt1;

    always #5 clk = ~clk;

    dma_fromhost_arb #(.CNT_W(CNT_W)) dut (
        .clk                     (clk),
        .rst                     (rst),
        .s0_axis_fromhost_tdata  (s0_tdata),
        .s0_axis_fromhost_tkeep  (s0_tkeep),
        .s0_axis_fromhost_tvalid (s0_tvalid),
        .s0_axis_fromhost_tlast  (s0_tlast),
        .s0_axis_fromhost_tready (s0_tready),
        .s1_axis_fromhost_tdata  (s1_tdata),
        .s1_axis_fromhost_tkeep  (s1_tkeep),
        .s1_axis_fromhost_tvalid (s1_tvalid),
        .s1_axis_fromhost_tlast  (s1_tlast),
        .s1_axis_fromhost_tready (s1_tready),
        .m_axis_fromhost_tdata   (m_tdata),
        .m_axis_fromhost_tkeep   (m_tkeep),
        .m_axis_fromhost_tvalid  (m_tvalid),
        .m_axis_fromhost_tlast   (m_tlast),
        .m_axis_fromhost_tready  (m_tready),
        .m_axis_fromhost_tid     (m_tid),
        .arb_busy                (arb_busy),
        .pkt_cnt0                (pkt_cnt0),
        .pkt_cnt1                (pkt_cnt1)
    );

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
    } beat_t;

    typedef struct packed {
        logic        tid;
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
        logic [7:0]  gap;   // cycles since previous accepted beat; 0 = don't care
    } exp_t;

    beat_t src0[$];
    beat_t src1[$];
    exp_t  exp_q[$];
    logic  rdy_q[$];

    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   last_acc = 0;
    logic bp_chk = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [63:0] beat_data(input int port, input int id, input int b);
        return {4'hA, 4'(port), 24'(id), 32'(b) * 32'h0101_0101};
    endfunction

    function automatic logic [7:0] beat_keep(input int b, input int n);
        logic [7:0] full;
        full = 8'hFF;
        return (b == n - 1) ? 8'h0F : (full >> (b % 8));
    endfunction

    task automatic src_pkt(input int port, input int id, input int n);
        for (int b = 0; b < n; b++) begin
            beat_t bt;
            bt.data = beat_data(port, id, b);
            bt.keep = beat_keep(b, n);
            bt.last = (b == n - 1);
            if (port == 0) src0.push_back(bt);
            else           src1.push_back(bt);
        end
    endtask

    task automatic exp_beat(input int port, input int id, input int b, input int n, input int gap);
        exp_t e;
        e.tid  = 1'(port);
        e.data = beat_data(port, id, b);
        e.keep = beat_keep(b, n);
        e.last = (b == n - 1);
        e.gap  = 8'(gap);
        exp_q.push_back(e);
    endtask

    task automatic exp_pkt(input int port, input int id, input int n, input int g0, input int g);
        for (int b = 0; b < n; b++) exp_beat(port, id, b, n, (b == 0) ? g0 : g);
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    task automatic wait_drain(input int budget, input string name);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk); #1;
            if (exp_q.size() == 0 && src0.size() == 0 && src1.size() == 0) return;
        end
        checks++;
        errors++;
        $display("FAIL %s_timeout: %0d expected beats left", name, exp_q.size());
    endtask

    task automatic do_reset();
        @(negedge clk); #2;
        rst = 1'b1;
        src0.delete();
        src1.delete();
        rdy_q.delete();
        @(posedge clk); #2;
        rst = 1'b0;
    endtask

    // Requester/sink driver: advances a source queue only after a sampled handshake.
    initial begin
        logic acc0, acc1;
        s0_tvalid = 1'b0; s0_tdata = '0; s0_tkeep = '0; s0_tlast = 1'b0;
        s1_tvalid = 1'b0; s1_tdata = '0; s1_tkeep = '0; s1_tlast = 1'b0;
        m_tready  = 1'b1;
        forever begin
            @(negedge clk);
            acc0 = s0_tvalid && s0_tready;
            acc1 = s1_tvalid && s1_tready;
            @(posedge clk); #1;
            if (acc0 && src0.size() > 0) void'(src0.pop_front());
            if (acc1 && src1.size() > 0) void'(src1.pop_front());
            if (src0.size() > 0) begin
                s0_tvalid = 1'b1; s0_tdata = src0[0].data; s0_tkeep = src0[0].keep; s0_tlast = src0[0].last;
            end else begin
                s0_tvalid = 1'b0; s0_tdata = '0; s0_tkeep = '0; s0_tlast = 1'b0;
            end
            if (src1.size() > 0) begin
                s1_tvalid = 1'b1; s1_tdata = src1[0].data; s1_tkeep = src1[0].keep; s1_tlast = src1[0].last;
            end else begin
                s1_tvalid = 1'b0; s1_tdata = '0; s1_tkeep = '0; s1_tlast = 1'b0;
            end
            m_tready = (rdy_q.size() > 0) ? rdy_q.pop_front() : 1'b1;
        end
    end

    // Monitor: every master handshake must match the head of the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (bp_chk) begin
                checks++;
                if (s1_tready !== 1'b0 || (arb_busy && s0_tready !== m_tready)) begin
                    errors++;
                    $display("FAIL bp_tready: s0=%b s1=%b m=%b busy=%b", s0_tready, s1_tready, m_tready, arb_busy);
                end
            end
            if (m_tvalid && m_tready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_beat: tid=%0d data=%h", m_tid, m_tdata);
                end else begin
                    exp_t e;
                    int   gap;
                    e   = exp_q.pop_front();
                    gap = cyc - last_acc;
                    if (m_tid !== e.tid || m_tdata !== e.data || m_tkeep !== e.keep ||
                        m_tlast !== e.last || (e.gap != 0 && gap != int'(e.gap))) begin
                        errors++;
                        $display("FAIL beat: got tid=%0d data=%h keep=%h last=%b gap=%0d expected tid=%0d data=%h keep=%h last=%b gap=%0d",
                                 m_tid, m_tdata, m_tkeep, m_tlast, gap, e.tid, e.data, e.keep, e.last, e.gap);
                    end
                end
                last_acc = cyc;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_busy",   64'(arb_busy),  64'd0);
        chk("rst_s0rdy",  64'(s0_tready), 64'd0);
        chk("rst_s1rdy",  64'(s1_tready), 64'd0);
        chk("rst_mvalid", 64'(m_tvalid),  64'd0);
        chk("rst_tid",    64'(m_tid),     64'd1);
        chk("rst_cnt0",   64'(pkt_cnt0),  64'd0);
        chk("rst_cnt1",   64'(pkt_cnt1),  64'd0);

        // Tie after reset: port 0 first, port 1 follows without a gap
        #2;
        src_pkt(0, 1, 3);
        src_pkt(1, 2, 3);
        exp_pkt(0, 1, 3, 2, 1);
        exp_pkt(1, 2, 3, 1, 1);
        last_acc = cyc;
        wait_drain(50, "tie");
        repeat (2) @(negedge clk);
        chk("tie_cnt0", 64'(pkt_cnt0), 64'd1);
        chk("tie_cnt1", 64'(pkt_cnt1), 64'd1);
        chk("tie_idle", 64'(arb_busy), 64'd0);

        // Fairness: 20 continuous 2-beat packets alternate strictly
        do_reset();
        @(negedge clk); #2;
        for (int i = 0; i < 10; i++) begin
            src_pkt(0, 100 + i, 2);
            src_pkt(1, 200 + i, 2);
            exp_pkt(0, 100 + i, 2, (i == 0) ? 2 : 1, 1);
            exp_pkt(1, 200 + i, 2, 1, 1);
        end
        last_acc = cyc;
        wait_drain(200, "fair");
        repeat (2) @(negedge clk);
        chk("fair_cnt0", 64'(pkt_cnt0), 64'd10);
        chk("fair_cnt1", 64'(pkt_cnt1), 64'd10);

        // Backpressure: m_tready 1,0,0,1 repeating on a 4-beat port 0 packet
        do_reset();
        @(negedge clk); #2;
        for (int i = 0; i < 3; i++) begin
            rdy_q.push_back(1'b1); rdy_q.push_back(1'b0);
            rdy_q.push_back(1'b0); rdy_q.push_back(1'b1);
        end
        src_pkt(0, 50, 4);
        exp_beat(0, 50, 0, 4, 4);
        exp_beat(0, 50, 1, 4, 1);
        exp_beat(0, 50, 2, 4, 3);
        exp_beat(0, 50, 3, 4, 1);
        last_acc = cyc;
        bp_chk = 1'b1;
        wait_drain(60, "bp");
        @(negedge clk);
        bp_chk = 1'b0;
        chk("bp_cnt0", 64'(pkt_cnt0), 64'd1);
        chk("bp_cnt1", 64'(pkt_cnt1), 64'd0);

        // Mid-packet reset after beat 2 of 5 on port 1
        @(negedge clk); #2;
        src_pkt(1, 7, 5);
        exp_beat(1, 7, 0, 5, 2);
        exp_beat(1, 7, 1, 5, 1);
        last_acc = cyc;
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
            @(negedge clk); #1;
        end
        chk("mrst_two_beats_seen", 64'(exp_q.size()), 64'd0);
        @(posedge clk); #2;
        rst = 1'b1;
        src1.delete();
        @(negedge clk);
        chk("mrst_during_busy",   64'(arb_busy),  64'd0);
        chk("mrst_during_s1rdy",  64'(s1_tready), 64'd0);
        chk("mrst_during_mvalid", 64'(m_tvalid),  64'd0);
        @(posedge clk); #2;
        rst = 1'b0;
        @(negedge clk);
        chk("mrst_after_busy",   64'(arb_busy),  64'd0);
        chk("mrst_after_s0rdy",  64'(s0_tready), 64'd0);
        chk("mrst_after_s1rdy",  64'(s1_tready), 64'd0);
        chk("mrst_after_mvalid", 64'(m_tvalid),  64'd0);
        chk("mrst_after_cnt0",   64'(pkt_cnt0),  64'd0);
        chk("mrst_after_cnt1",   64'(pkt_cnt1),  64'd0);
        #2;
        src_pkt(0, 8, 1);
        src_pkt(1, 9, 1);
        exp_pkt(0, 8, 1, 2, 1);
        exp_pkt(1, 9, 1, 1, 1);
        last_acc = cyc;
        wait_drain(30, "mrst_tie");
        repeat (2) @(negedge clk);
        chk("mrst_tie_cnt0", 64'(pkt_cnt0), 64'd1);
        chk("mrst_tie_cnt1", 64'(pkt_cnt1), 64'd1);

        // Counter wrap: 17 single-beat packets, one idle cycle between each
        do_reset();
        @(negedge clk); #2;
        for (int i = 0; i < 17; i++) begin
            src_pkt(0, 300 + i, 1);
            exp_pkt(0, 300 + i, 1, 2, 2);
        end
        last_acc = cyc;
        wait_drain(100, "wrap");
        repeat (2) @(negedge clk);
        chk("wrap_cnt0", 64'(pkt_cnt0), 64'd1);
        chk("wrap_cnt1", 64'(pkt_cnt1), 64'd0);

        repeat (3) @(negedge clk);
        chk("final_scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
